// File: rtl/seven_seg_scanner_if.sv
// Core-to-display bus for the eight-digit hex scanner: write port, blanking
// control, readback and the active-low display pins.
interface seven_seg_scanner_if;
    logic        DataWE;
    logic [31:0] DataIn;
    logic        BlankLZ;
    logic [31:0] Shown;
    logic [7:0]  SevenSegAn;
    logic [6:0]  SevenSegCat;
    logic        ScanDone;

    modport master (
        output DataWE, DataIn, BlankLZ,
        input  Shown, SevenSegAn, SevenSegCat, ScanDone
    );

    modport slave (
        input  DataWE, DataIn, BlankLZ,
        output Shown, SevenSegAn, SevenSegCat, ScanDone
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed eight-digit hex display driver with optional leading-zero
// blanking; all display outputs are registered one cycle behind the scan state.
module seven_seg_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  CLK,
    input  logic                  Reset,
    seven_seg_scanner_if.slave    bus
);
    localparam int              PRE_W    = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

    logic [31:0]      r_shown;
    logic [PRE_W-1:0] r_pre;
    logic [2:0]       r_idx;
    logic [7:0]       r_an;
    logic [6:0]       r_cat;
    logic             r_wrap;
    logic             r_done;

    logic [3:0]       w_nibble;
    logic             w_pre_wrap;
    logic             w_frame_wrap;
    logic             w_blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h10;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    // Digit 0 is never blanked so a zero value still shows a single "0".
    function automatic logic lz_blank(input logic [31:0] val, input logic [2:0] idx,
                                      input logic en);
        lz_blank = en && (idx != 3'd0) && ((val >> {idx, 2'b00}) == 32'd0);
    endfunction

    assign w_nibble     = r_shown[{r_idx, 2'b00} +: 4];
    assign w_pre_wrap   = (r_pre == PRE_LAST);
    assign w_frame_wrap = w_pre_wrap && (r_idx == 3'd7);
    assign w_blank      = lz_blank(r_shown, r_idx, bus.BlankLZ);

    // r_wrap marks the idx 7->0 step; ScanDone follows it so the pulse lines up
    // with the registered anode moving onto digit 0.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_shown <= 32'd0;
            r_pre   <= '0;
            r_idx   <= 3'd0;
            r_an    <= 8'hFF;
            r_cat   <= 7'h7F;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_pre  <= w_pre_wrap ? '0 : r_pre + PRE_W'(1);
            if (w_pre_wrap) begin
                r_idx <= r_idx + 3'd1;
            end
            if (bus.DataWE) begin
                r_shown <= bus.DataIn;
            end
            r_wrap <= w_frame_wrap;
            r_done <= r_wrap;
            if (w_blank) begin
                r_an  <= 8'hFF;
                r_cat <= 7'h7F;
            end else begin
                r_an  <= ~(8'd1 << r_idx);
                r_cat <= seg_decode(w_nibble);
            end
        end
    end

    assign bus.Shown       = r_shown;
    assign bus.SevenSegAn  = r_an;
    assign bus.SevenSegCat = r_cat;
    assign bus.ScanDone    = r_done;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner with REFRESH_DIV = 4: stimulus queues
// cycle-stamped expectations, a monitor compares them against the display pins.
module tb_seven_seg_scanner;
    localparam int DIV = 4;

    logic CLK = 1'b0;
    logic Reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   base;

    typedef struct {
        int          at;
        bit          is_shown;
        logic [7:0]  an;
        logic [6:0]  cat;
        logic        done;
        logic [31:0] shown;
        string       name;
    } exp_t;

    exp_t q[$];

    seven_seg_scanner_if bus();

    seven_seg_scanner #(.REFRESH_DIV(DIV)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic push(input exp_t e);
        int i;
        i = 0;
        while (i < q.size() && q[i].at <= e.at) i++;
        q.insert(i, e);
    endtask

    task automatic exp_disp(input int at, input logic [7:0] an, input logic [6:0] cat,
                            input logic done, input string name);
        exp_t e;
        e.at = at; e.is_shown = 1'b0; e.an = an; e.cat = cat; e.done = done;
        e.shown = 32'd0; e.name = name;
        push(e);
    endtask

    task automatic exp_shown(input int at, input logic [31:0] v, input string name);
        exp_t e;
        e.at = at; e.is_shown = 1'b1; e.an = 8'h00; e.cat = 7'h00; e.done = 1'b0;
        e.shown = v; e.name = name;
        push(e);
    endtask

    // Monitor: samples 1 time unit after each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #1;
            while (q.size() > 0 && q[0].at <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.at < cyc) begin
                    errors++;
                    $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)",
                             e.name, e.at, cyc);
                end else if (e.is_shown) begin
                    if (bus.Shown !== e.shown) begin
                        errors++;
                        $display("FAIL %s: Shown=%h, expected %h", e.name, bus.Shown, e.shown);
                    end
                end else if (bus.SevenSegAn !== e.an || bus.SevenSegCat !== e.cat ||
                             bus.ScanDone !== e.done) begin
                    errors++;
                    $display("FAIL %s: an=%h cat=%h done=%b, expected an=%h cat=%h done=%b",
                             e.name, bus.SevenSegAn, bus.SevenSegCat, bus.ScanDone,
                             e.an, e.cat, e.done);
                end
            end
        end
    end

    initial begin
        logic [6:0] scan_cat [8];
        scan_cat = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};

        Reset = 1'b1;
        bus.DataWE = 1'b0;
        bus.DataIn = 32'd0;
        bus.BlankLZ = 1'b0;

        // Reset held for three rising edges.
        repeat (3) @(negedge CLK);
        exp_disp(cyc, 8'hFF, 7'h7F, 1'b0, "reset_out");
        exp_shown(cyc, 32'd0, "reset_shown");

        // Full scan of 89ABCDEF, write issued on the first cycle after release.
        base = cyc;
        Reset = 1'b0;
        bus.DataWE = 1'b1;
        bus.DataIn = 32'h89ABCDEF;
        exp_disp(base + 1, 8'hFE, 7'h40, 1'b0, "first_after_reset");
        for (int p = 2; p <= 36; p++) begin
            int d;
            d = ((p - 1) / DIV) % 8;
            exp_disp(base + p, ~(8'd1 << d), scan_cat[d], (p == 33), $sformatf("scan_p%0d", p));
        end
        exp_disp(base + 64, 8'h7F, 7'h00, 1'b0, "scan_p64");
        exp_disp(base + 65, 8'hFE, 7'h0E, 1'b1, "scan_done_period");
        exp_shown(base + 2, 32'h89ABCDEF, "scan_shown");
        @(negedge CLK);
        bus.DataWE = 1'b0;
        repeat (64) @(negedge CLK);

        // Leading-zero blanking of 00000120, then of 0.
        Reset = 1'b1;
        @(negedge CLK);
        base = cyc;
        Reset = 1'b0;
        bus.DataWE = 1'b1;
        bus.DataIn = 32'h00000120;
        bus.BlankLZ = 1'b1;
        exp_disp(base + 1,  8'hFE, 7'h40, 1'b0, "blk_d0_a");
        exp_disp(base + 4,  8'hFE, 7'h40, 1'b0, "blk_d0_b");
        exp_disp(base + 5,  8'hFD, 7'h24, 1'b0, "blk_d1_a");
        exp_disp(base + 8,  8'hFD, 7'h24, 1'b0, "blk_d1_b");
        exp_disp(base + 9,  8'hFB, 7'h79, 1'b0, "blk_d2_a");
        exp_disp(base + 12, 8'hFB, 7'h79, 1'b0, "blk_d2_b");
        exp_disp(base + 13, 8'hFF, 7'h7F, 1'b0, "blk_d3");
        exp_disp(base + 20, 8'hFF, 7'h7F, 1'b0, "blk_d4");
        exp_disp(base + 32, 8'hFF, 7'h7F, 1'b0, "blk_d7");
        exp_disp(base + 33, 8'hFE, 7'h40, 1'b1, "blk_wrap");
        @(negedge CLK);
        bus.DataWE = 1'b0;
        repeat (32) @(negedge CLK);
        bus.DataWE = 1'b1;
        bus.DataIn = 32'd0;
        exp_shown(base + 34, 32'd0, "zero_shown");
        exp_disp(base + 34, 8'hFE, 7'h40, 1'b0, "zero_d0_a");
        exp_disp(base + 36, 8'hFE, 7'h40, 1'b0, "zero_d0_b");
        exp_disp(base + 37, 8'hFF, 7'h7F, 1'b0, "zero_d1");
        exp_disp(base + 45, 8'hFF, 7'h7F, 1'b0, "zero_d3");
        exp_disp(base + 64, 8'hFF, 7'h7F, 1'b0, "zero_d7");
        exp_disp(base + 65, 8'hFE, 7'h40, 1'b1, "zero_wrap");
        @(negedge CLK);
        bus.DataWE = 1'b0;
        repeat (31) @(negedge CLK);

        // Mid-slot write, slot-boundary write and continuous write.
        Reset = 1'b1;
        @(negedge CLK);
        base = cyc;
        Reset = 1'b0;
        bus.BlankLZ = 1'b0;
        exp_disp(base + 1,  8'hFE, 7'h40, 1'b0, "mid_d0");
        exp_disp(base + 8,  8'hFD, 7'h40, 1'b0, "mid_d1");
        exp_disp(base + 10, 8'hFB, 7'h40, 1'b0, "mid_before");
        exp_disp(base + 11, 8'hFB, 7'h0E, 1'b0, "mid_after");
        exp_disp(base + 12, 8'hFB, 7'h0E, 1'b0, "mid_hold");
        exp_disp(base + 13, 8'hF7, 7'h40, 1'b0, "mid_cadence");
        exp_disp(base + 16, 8'hF7, 7'h40, 1'b0, "edge_no_glitch");
        exp_disp(base + 17, 8'hEF, 7'h03, 1'b0, "edge_next_slot");
        exp_disp(base + 18, 8'hEF, 7'h46, 1'b0, "held_last_wins");
        exp_disp(base + 33, 8'hFE, 7'h40, 1'b1, "mid_wrap");
        exp_shown(base + 16, 32'h000B0F00, "held_shown_1");
        exp_shown(base + 17, 32'h000C0F00, "held_shown_2");
        repeat (9) @(negedge CLK);
        bus.DataWE = 1'b1;
        bus.DataIn = 32'h00000F00;
        @(negedge CLK);
        bus.DataWE = 1'b0;
        repeat (5) @(negedge CLK);
        bus.DataWE = 1'b1;
        bus.DataIn = 32'h000B0F00;
        @(negedge CLK);
        bus.DataIn = 32'h000C0F00;
        @(negedge CLK);
        bus.DataWE = 1'b0;
        repeat (16) @(negedge CLK);

        // Reset wins over a simultaneous write.
        Reset = 1'b1;
        bus.DataWE = 1'b1;
        bus.DataIn = 32'hFFFFFFFF;
        @(negedge CLK);
        exp_disp(cyc, 8'hFF, 7'h7F, 1'b0, "prio_out");
        exp_shown(cyc, 32'd0, "prio_shown");
        base = cyc;
        Reset = 1'b0;
        bus.DataWE = 1'b0;
        exp_disp(base + 1,  8'hFE, 7'h40, 1'b0, "prio_d0_a");
        exp_disp(base + 4,  8'hFE, 7'h40, 1'b0, "prio_d0_b");
        exp_disp(base + 5,  8'hFD, 7'h40, 1'b0, "prio_d1");
        exp_disp(base + 21, 8'hDF, 7'h40, 1'b0, "prio_d5_a");
        exp_disp(base + 22, 8'hDF, 7'h40, 1'b0, "prio_d5_b");
        repeat (22) @(negedge CLK);

        // Reset pulse while digit 5 is lit.
        Reset = 1'b1;
        @(negedge CLK);
        exp_disp(cyc, 8'hFF, 7'h7F, 1'b0, "midrst_out");
        base = cyc;
        Reset = 1'b0;
        exp_disp(base + 1, 8'hFE, 7'h40, 1'b0, "midrst_d0_a");
        exp_disp(base + 4, 8'hFE, 7'h40, 1'b0, "midrst_d0_b");
        exp_disp(base + 5, 8'hFD, 7'h40, 1'b0, "midrst_d1_a");
        exp_disp(base + 8, 8'hFD, 7'h40, 1'b0, "midrst_d1_b");
        exp_disp(base + 9, 8'hFB, 7'h40, 1'b0, "midrst_d2");
        repeat (10) @(negedge CLK);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge CLK);
        #2;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
